// File: rtl/dbg_regfile_pkg.sv
// Shared types and constants for the debug register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbg_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Default burst-length field width and the matching beat-counter width.
  // The counter needs one extra bit so a full-length burst (2**LEN_BITS beats) fits.
  localparam int LEN_BITS_DEF = 8;
  localparam int BEAT_CNT_W   = LEN_BITS_DEF + 1;

  function automatic int beat_cnt_w(input int len_bits);
    return len_bits + 1;
  endfunction

endpackage

// File: rtl/dbg_regfile_mem.sv
// Register storage with a host and a local write port (host wins) and two masked read ports.
// Latency: reads combinational; writes visible the cycle after the write edge.
// Backpressure: none; drop/error indications are combinational for the parent to register.
module dbg_regfile_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 8,
  parameter int DEPTH      = 256,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  h_we,
  input  logic [ADDR_BITS-1:0]  h_waddr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  input  logic                  l_we,
  input  logic [ADDR_BITS-1:0]  l_waddr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  input  logic [ADDR_BITS-1:0]  h_raddr,
  output logic [DATA_WIDTH-1:0] h_rdata,
  output logic                  h_roor,
  input  logic [ADDR_BITS-1:0]  l_raddr,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  h_werr,
  output logic                  l_werr,
  output logic                  l_drop
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic is_zero(input logic [ADDR_BITS-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_BITS-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_BITS-1:0] a);
    if (!in_range(a) || is_zero(a)) return '0;
    return mem_q[idx(a)];
  endfunction

  logic h_ok;
  logic l_ok;

  assign h_rdata = rd(h_raddr);
  assign l_rdata = rd(l_raddr);
  assign h_roor  = !in_range(h_raddr);

  // Local write loses to a host write on the same address; protected or
  // out-of-range writes are dropped and reported.
  assign l_drop = l_we && h_we && (l_waddr == h_waddr);
  assign h_ok   = h_we && in_range(h_waddr) && !is_zero(h_waddr);
  assign l_ok   = l_we && !l_drop && in_range(l_waddr) && !is_zero(l_waddr);
  assign h_werr = h_we && !h_ok;
  assign l_werr = l_we && !l_drop && !l_ok;

  // Next array contents: apply the local write, then the host write.
  always_comb begin
    mem_d = mem_q;
    if (l_ok) mem_d[idx(l_waddr)] = l_wdata;
    if (h_ok) mem_d[idx(h_waddr)] = h_wdata;
  end

  // Storage; reset clears every register so an aborted burst leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/dbg_regfile.sv
// Debug register file: burst command port for the UART decoder plus a local access port.
// Latency: first read beat one cycle after command accept, then one beat/cycle; writes one beat/cycle.
// Backpressure: cmd_ready only in IDLE, wdata_ready only in WRITE, read beat held until rdata_ready.
module dbg_regfile
  import dbg_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 8,
  parameter int DEPTH      = 256,
  parameter int LEN_BITS   = 8,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_BITS-1:0]  cmd_addr,
  input  logic [LEN_BITS-1:0]   cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  input  logic [ADDR_BITS-1:0]  loc_raddr,
  output logic [DATA_WIDTH-1:0] loc_rdata,
  input  logic                  loc_we,
  input  logic [ADDR_BITS-1:0]  loc_waddr,
  input  logic [DATA_WIDTH-1:0] loc_wdata,
  output logic                  collision,
  output logic                  err
);

  localparam int CNT_W = beat_cnt_w(LEN_BITS);

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]      beats_q, beats_d;
  logic                  rvld_q, rvld_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  rlast_q, rlast_d;
  logic                  coll_q, coll_d;
  logic                  err_q, err_d;

  logic                  h_we;
  logic                  rd_load;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0] h_rdata;
  logic                  h_roor;
  logic                  h_werr;
  logic                  l_werr;
  logic                  l_drop;

  function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a);
    if (a == ADDR_BITS'(DEPTH - 1)) return '0;
    return a + ADDR_BITS'(1);
  endfunction

  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign rdata_valid = rvld_q;
  assign rdata       = rdat_q;
  assign rdata_last  = rlast_q;
  assign collision   = coll_q;
  assign err         = err_q;

  assign h_we    = (state_q == WRITE) && wdata_valid;
  // The first read beat is fetched at command accept, so the read port
  // looks at cmd_addr while idle and at the running address afterwards.
  assign rd_addr = (state_q == IDLE) ? cmd_addr : addr_q;

  dbg_regfile_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS),
    .DEPTH      (DEPTH),
    .ZERO_REG   (ZERO_REG)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .h_we    (h_we),
    .h_waddr (addr_q),
    .h_wdata (wdata),
    .l_we    (loc_we),
    .l_waddr (loc_waddr),
    .l_wdata (loc_wdata),
    .h_raddr (rd_addr),
    .h_rdata (h_rdata),
    .h_roor  (h_roor),
    .l_raddr (loc_raddr),
    .l_rdata (loc_rdata),
    .h_werr  (h_werr),
    .l_werr  (l_werr),
    .l_drop  (l_drop)
  );

  // Next-state, burst bookkeeping and read output register control.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    rvld_d  = rvld_q;
    rdat_d  = rdat_q;
    rlast_d = rlast_q;
    rd_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            state_d = WRITE;
            addr_d  = cmd_addr;
            beats_d = CNT_W'(cmd_len) + CNT_W'(1);
          end else begin
            // Load beat 0 immediately; beats_q then counts beats still to load.
            state_d = READ;
            rd_load = 1'b1;
            rvld_d  = 1'b1;
            rdat_d  = h_rdata;
            rlast_d = (cmd_len == '0);
            addr_d  = next_addr(cmd_addr);
            beats_d = CNT_W'(cmd_len);
          end
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          addr_d  = next_addr(addr_q);
          beats_d = beats_q - CNT_W'(1);
          if (beats_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      READ: begin
        if (rvld_q && rdata_ready) begin
          rvld_d  = 1'b0;
          rlast_d = 1'b0;
          if (rlast_q) state_d = IDLE;
        end
        if ((beats_q != '0) && (!rvld_q || rdata_ready)) begin
          rd_load = 1'b1;
          rvld_d  = 1'b1;
          rdat_d  = h_rdata;
          rlast_d = (beats_q == CNT_W'(1));
          addr_d  = next_addr(addr_q);
          beats_d = beats_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    coll_d = l_drop;
    err_d  = h_werr || l_werr || (rd_load && h_roor);
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      rvld_q  <= 1'b0;
      rdat_q  <= '0;
      rlast_q <= 1'b0;
      coll_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      rvld_q  <= rvld_d;
      rdat_q  <= rdat_d;
      rlast_q <= rlast_d;
      coll_q  <= coll_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dbg_regfile.sv
// Bench for dbg_regfile: a 256-entry and a 200-entry instance share all inputs.
// Expected read beats come from per-depth reference models and are queued at command time.
// A negedge monitor pops and compares every read handshake and checks stall stability.
module tb_dbg_regfile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h0;
  logic [7:0] cmd_len = 8'h0;
  logic       wdata_valid = 1'b0;
  logic [7:0] wdata = 8'h0;
  logic       rdata_ready = 1'b1;
  logic [7:0] loc_raddr = 8'h0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_waddr = 8'h0;
  logic [7:0] loc_wdata = 8'h0;

  logic       a_cmd_ready, a_wdata_ready, a_rdata_valid, a_rdata_last, a_collision, a_err;
  logic [7:0] a_rdata, a_loc_rdata;
  logic       b_cmd_ready, b_wdata_ready, b_rdata_valid, b_rdata_last, b_collision, b_err;
  logic [7:0] b_rdata, b_loc_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0] m256 [256];
  logic [7:0] m200 [256];
  logic [8:0] qa [$];
  logic [8:0] qb [$];
  logic [7:0] wbuf [16];

  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_dat = 8'h0;
  logic       prev_last = 1'b0;

  always #5 clk = ~clk;

  dbg_regfile #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(a_wdata_ready), .wdata(wdata),
    .rdata_valid(a_rdata_valid), .rdata_ready(rdata_ready), .rdata(a_rdata),
    .rdata_last(a_rdata_last),
    .loc_raddr(loc_raddr), .loc_rdata(a_loc_rdata),
    .loc_we(loc_we), .loc_waddr(loc_waddr), .loc_wdata(loc_wdata),
    .collision(a_collision), .err(a_err)
  );

  dbg_regfile #(.DEPTH(200)) dut200 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(b_wdata_ready), .wdata(wdata),
    .rdata_valid(b_rdata_valid), .rdata_ready(rdata_ready), .rdata(b_rdata),
    .rdata_last(b_rdata_last),
    .loc_raddr(loc_raddr), .loc_rdata(b_loc_rdata),
    .loc_we(loc_we), .loc_waddr(loc_waddr), .loc_wdata(loc_wdata),
    .collision(b_collision), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input int d, input logic [7:0] a);
    return (int'(a) == d - 1) ? 8'h00 : a + 8'h01;
  endfunction

  function automatic logic [7:0] mrd(input int d, input logic [7:0] a);
    if (int'(a) >= d || a == 8'h00) return 8'h00;
    return (d == 256) ? m256[a] : m200[a];
  endfunction

  function automatic void mw(input int d, input logic [7:0] a, input logic [7:0] v);
    if (int'(a) < d && a != 8'h00) begin
      if (d == 256) m256[a] = v;
      else m200[a] = v;
    end
  endfunction

  function automatic void mclear();
    for (int i = 0; i < 256; i++) begin
      m256[i] = 8'h00;
      m200[i] = 8'h00;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-side monitor: scoreboard pops on handshake, stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld <= 1'b0;
      prev_rdy <= 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        chk("hold_vld", 32'(a_rdata_valid), 32'd1);
        chk("hold_dat", 32'({a_rdata_last, a_rdata}), 32'({prev_last, prev_dat}));
      end
      if (a_rdata_valid && rdata_ready) begin
        if (qa.size() == 0) chk("rd_extra_a", 32'd1, 32'd0);
        else chk("rdata_a", 32'({a_rdata_last, a_rdata}), 32'(qa.pop_front()));
      end
      if (b_rdata_valid && rdata_ready) begin
        if (qb.size() == 0) chk("rd_extra_b", 32'd1, 32'd0);
        else chk("rdata_b", 32'({b_rdata_last, b_rdata}), 32'(qb.pop_front()));
      end
      prev_vld  <= a_rdata_valid;
      prev_rdy  <= rdata_ready;
      prev_dat  <= a_rdata;
      prev_last <= a_rdata_last;
    end
  end

  task automatic host_write(input logic [7:0] a, input int n);
    logic [7:0] x;
    logic [7:0] y;
    x = a;
    y = a;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = a;
    cmd_len   = 8'(n - 1);
    chk("wr_cmd_rdy", 32'(a_cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      wdata_valid = 1'b1;
      wdata = wbuf[i];
      chk("wr_rdy", 32'(a_wdata_ready), 32'd1);
      mw(256, x, wbuf[i]);
      mw(200, y, wbuf[i]);
      x = nxt(256, x);
      y = nxt(200, y);
      tick();
    end
    wdata_valid = 1'b0;
    chk("wr_done_rdy", 32'(a_cmd_ready), 32'd1);
  endtask

  task automatic read_burst(input logic [7:0] a, input int len, input bit stall);
    logic [7:0] x;
    logic [7:0] y;
    int n;
    x = a;
    y = a;
    for (int i = 0; i <= len; i++) begin
      qa.push_back({i == len, mrd(256, x)});
      qb.push_back({i == len, mrd(200, y)});
      x = nxt(256, x);
      y = nxt(200, y);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    cmd_len   = 8'(len);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 1000) begin
      rdata_ready = stall ? (n % 2 == 1) : 1'b1;
      tick();
      n++;
    end
    rdata_ready = 1'b1;
    chk("rd_drain", 32'(qa.size() + qb.size()), 32'd0);
    chk("rd_done_rdy", 32'(a_cmd_ready), 32'd1);
  endtask

  task automatic loc_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    loc_raddr = a;
    #1;
    chk(tag, 32'(a_loc_rdata), 32'(exp));
  endtask

  initial begin
    mclear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_cmd_rdy", 32'(a_cmd_ready), 32'd1);
    chk("rst_wdata_rdy", 32'(a_wdata_ready), 32'd0);
    chk("rst_rvld", 32'(a_rdata_valid), 32'd0);
    chk("rst_rdata", 32'(a_rdata), 32'd0);
    chk("rst_rlast", 32'(a_rdata_last), 32'd0);
    chk("rst_coll", 32'(a_collision), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_rvld_b", 32'(b_rdata_valid), 32'd0);

    // Basic burst write and read back.
    wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3; wbuf[3] = 8'hA4;
    host_write(8'h10, 4);
    chk("wr_no_err", 32'(a_err), 32'd0);
    loc_chk("loc_13", 8'h13, 8'hA4);
    read_burst(8'h10, 3, 1'b0);

    // Wrap through the top of the array and the zero register, with stalls.
    wbuf[0] = 8'hB1; wbuf[1] = 8'hB2; wbuf[2] = 8'hB3; wbuf[3] = 8'hB4;
    host_write(8'hFE, 4);
    read_burst(8'hFE, 3, 1'b1);

    // Same-address collision: host wins.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_len = 8'h00;
    tick();
    cmd_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 8'h55;
    loc_we = 1'b1; loc_waddr = 8'h20; loc_wdata = 8'hAA;
    mw(256, 8'h20, 8'h55); mw(200, 8'h20, 8'h55);
    tick();
    wdata_valid = 1'b0; loc_we = 1'b0;
    chk("coll_pulse", 32'(a_collision), 32'd1);
    loc_chk("coll_val", 8'h20, 8'h55);
    tick();
    chk("coll_clear", 32'(a_collision), 32'd0);

    // Different addresses in the same cycle: both commit.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 8'h00;
    tick();
    cmd_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 8'h11;
    loc_we = 1'b1; loc_waddr = 8'h41; loc_wdata = 8'h22;
    mw(256, 8'h40, 8'h11); mw(200, 8'h40, 8'h11);
    mw(256, 8'h41, 8'h22); mw(200, 8'h41, 8'h22);
    tick();
    wdata_valid = 1'b0; loc_we = 1'b0;
    chk("nocoll", 32'(a_collision), 32'd0);
    loc_chk("both_40", 8'h40, 8'h11);
    loc_chk("both_41", 8'h41, 8'h22);

    // Protected register 0, host then local.
    wbuf[0] = 8'h77;
    host_write(8'h00, 1);
    chk("zero_err", 32'(a_err), 32'd1);
    loc_chk("zero_rd", 8'h00, 8'h00);
    tick();
    chk("zero_err_clr", 32'(a_err), 32'd0);
    loc_we = 1'b1; loc_waddr = 8'h00; loc_wdata = 8'h33;
    tick();
    loc_we = 1'b0;
    chk("zero_lerr", 32'(a_err), 32'd1);
    loc_chk("zero_rd2", 8'h00, 8'h00);

    // Out-of-range on the 200-entry instance, and wrap at DEPTH-1.
    tick();
    wbuf[0] = 8'h5A;
    host_write(8'hC8, 1);
    chk("oor_err_b", 32'(b_err), 32'd1);
    chk("oor_noerr_a", 32'(a_err), 32'd0);
    loc_raddr = 8'hC8;
    #1;
    chk("oor_loc_b", 32'(b_loc_rdata), 32'd0);
    chk("oor_loc_a", 32'(a_loc_rdata), 32'h5A);
    wbuf[0] = 8'h99; wbuf[1] = 8'h9A;
    host_write(8'hC7, 2);
    read_burst(8'hC7, 1, 1'b0);

    // Local write visibility the cycle after the edge.
    loc_we = 1'b1; loc_waddr = 8'h30; loc_wdata = 8'h3C;
    mw(256, 8'h30, 8'h3C); mw(200, 8'h30, 8'h3C);
    tick();
    loc_we = 1'b0;
    loc_chk("loc_vis", 8'h30, 8'h3C);

    // Maximum length burst wraps the whole array.
    read_burst(8'h05, 255, 1'b0);

    // Reset during beat 2 of a 4-beat read.
    for (int i = 0; i < 4; i++) begin
      qa.push_back({i == 3, mrd(256, 8'(8'h10 + i))});
      qb.push_back({i == 3, mrd(200, 8'(8'h10 + i))});
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 8'h03;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    mclear();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_rvld", 32'(a_rdata_valid), 32'd0);
    chk("abort_cmd_rdy", 32'(a_cmd_ready), 32'd1);
    chk("abort_rvld_b", 32'(b_rdata_valid), 32'd0);
    loc_chk("abort_10", 8'h10, 8'h00);
    loc_chk("abort_13", 8'h13, 8'h00);
    loc_chk("abort_20", 8'h20, 8'h00);
    loc_chk("abort_41", 8'h41, 8'h00);
    loc_chk("abort_FF", 8'hFF, 8'h00);
    read_burst(8'h10, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dbg_regfile.md
# dbg_regfile

Parametrised debug register file for the UART debugger. A burst command port serves the UART command decoder: single or multi-beat reads and writes with auto-incrementing, wrapping addresses and valid/ready flow control on both data directions. A local port serves on-chip logic with a combinational read and a single-cycle write. Register 0 optionally reads as zero and ignores writes. Host/local write collisions are resolved deterministically and flagged.

## Interface
- DATA_WIDTH, 8, register width
- ADDR_BITS, 8, address width
- DEPTH, 256, number of registers, 2 ≤ DEPTH ≤ 2**ADDR_BITS
- LEN_BITS, 8, burst length field width
- ZERO_REG, 1, 1: register 0 reads '0 and is write-protected
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_BITS  start address
- cmd_len  in  LEN_BITS  beats minus one
- wdata_valid / wdata_ready  in / out  1  write-data handshake
- wdata  in  DATA_WIDTH  write beat
- rdata_valid / rdata_ready  out / in  1  read-data handshake
- rdata  out  DATA_WIDTH  read beat
- rdata_last  out  1  final beat of burst
- loc_raddr  in  ADDR_BITS; loc_rdata  out  DATA_WIDTH  combinational local read
- loc_we  in  1; loc_waddr  in  ADDR_BITS; loc_wdata  in  DATA_WIDTH  local write
- collision  out  1  registered pulse: local write dropped
- err  out  1  registered pulse: protected or out-of-range access

## Operation
- FSM states: IDLE, WRITE, READ. cmd_ready = (state == IDLE). Command accepted on cmd_valid & cmd_ready. Accept latches addr and beats = cmd_len + 1, then moves to WRITE or READ.
- WRITE: wdata_ready = 1. Each wdata handshake writes mem[addr], advances addr, and decrements the count. IDLE follows the final beat.
- READ: a one-entry output register is loaded from mem[addr] when beats remain and (!rdata_valid | rdata_ready). rdata_valid, rdata and rdata_last hold stable until rdata_ready. IDLE follows the final handshake.
- Address advance: next = (addr == DEPTH-1) ? 0 : addr + 1, modulo 2**ADDR_BITS.
- Address ≥ DEPTH: the write is dropped, the read returns '0, and err pulses.
- ZERO_REG = 1: reads of address 0 return '0 on both ports. A host or local write to 0 is dropped and err pulses.
- Host write and loc_we to the same address in the same cycle: the host wins, the local write is dropped, and collision pulses. Different addresses: both writes commit.
- A read load in the same cycle as a write to that address returns the old value. Later beats see the new value.
- cmd_len maximum (2**LEN_BITS beats) is legal and may wrap the whole array.

## Timing
- Reset: all registers '0, state IDLE, cmd_ready 1, wdata_ready 0, rdata_valid 0, rdata '0, rdata_last 0, collision 0, err 0.
- Reset mid-burst aborts the burst. Remaining beats are discarded and writes already committed are also cleared.
- Writes are visible on loc_rdata the cycle after the write edge.
- Read latency: first rdata_valid one cycle after the command handshake. Full throughput is one beat per cycle while rdata_ready = 1.
- Write throughput is one beat per cycle. The cycle after the last wdata handshake shows cmd_ready = 1.
- collision and err assert for exactly one cycle, the cycle after the offending edge.

## Structure
- Package dbg_regfile_pkg holds the state enum (IDLE, WRITE, READ) and the beat-counter width constant (LEN_BITS+1).
- Sub-module dbg_regfile_mem holds the storage array. It provides two write ports with host priority, zero/out-of-range read masking, and two read ports. The FSM and handshakes live in dbg_regfile.

## Test plan
- Reset, then write burst addr 0x10, len 3, data A1..A4 → regs 0x10..0x13 hold A1..A4; read burst returns them with rdata_last on beat 4.
- Read burst addr 0xFE, len 3, rdata_ready toggling 1/0 → beats are from 0xFE, 0xFF, 0x00 (='0), 0x01; each value is held while stalled; no beat is lost or duplicated.
- Host write 0x55 and local write 0xAA to 0x20 in the same cycle → reg 0x20 = 0x55 and collision pulses one cycle.
- Write 0x77 to address 0 with ZERO_REG = 1 → err pulses; loc_rdata for address 0 = 0x00.
- DEPTH = 200, write to 0xC8 → dropped and err pulses; a burst from 199 wraps to 0.
- Assert rst_n low during beat 2 of a 4-beat read → rdata_valid 0 and cmd_ready 1 after release; all registers read 0.
